display_nibble_scheduler: RTL and testbench
===========================================

Name: display_nibble_scheduler

Overview:
- Time-multiplexes a 32-bit value, such as data-memory word 0 (the counter) from the pipeline CPU, onto the single seven-segment decoder, one hex nibble at a time.
- Sits between the CPU's data_mem0 output and Seven_Segment_Display, replacing the fixed low-nibble tap.
- Each frame snapshots the word, then steps from the most-significant to the least-significant nibble, with a dwell period and an inter-digit blank gap.
- Optional leading-zero suppression.

Parameters:
- DWELL_CYCLES, default 1000: clock cycles each nibble is displayed; must be >= 1.
- BLANK_CYCLES, default 100: blank-gap cycles after each nibble; 0 means the gap is skipped.
- NUM_NIBBLES, default 8: nibbles per word; fixed at 8 for a 32-bit value.
- SUPPRESS_LZ, default 0: when 1, a frame starts at the highest non-zero nibble.

Ports:
- clk  input  1  system clock, shared with the CPU.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  run the scheduler; low forces IDLE.
- value  input  32  word to display; sampled only in SNAP.
- hold  input  1  when high in SNAP, the previous snapshot is retained.
- nibble_value  output  4  nibble to drive Seven_Segment_Display.value.
- nibble_idx  output  3  index of the displayed nibble; 7 is the MSN.
- blank  output  1  1 means the segments must be driven off.
- frame_start  output  1  one-cycle pulse in the SNAP cycle.

Behaviour:
- Reset (reset=0, asynchronous, no clock edge needed):
  - state=IDLE, snapshot=0, dwell counter=0.
  - nibble_value=0, nibble_idx=0, blank=1, frame_start=0.
- All outputs are registered.
- States: IDLE, SNAP, SHOW, GAP.
- IDLE:
  - blank=1.
  - enable=1 -> SNAP on the next edge.
- SNAP (exactly 1 cycle):
  - frame_start=1, blank=1.
  - If hold=0, snapshot<=value; if hold=1, snapshot is unchanged.
  - Start index:
    - SUPPRESS_LZ=0: 7.
    - SUPPRESS_LZ=1: index of the highest non-zero nibble of the new (or held) snapshot; 0 if the snapshot is 0.
  - -> SHOW.
- SHOW (exactly DWELL_CYCLES cycles):
  - blank=0.
  - nibble_value=snapshot[4*idx+3:4*idx], nibble_idx=idx.
  - At the end of the dwell: -> GAP if BLANK_CYCLES>0; otherwise -> next step (below).
- GAP (exactly BLANK_CYCLES cycles):
  - blank=1.
  - nibble_idx and nibble_value hold their last values.
  - At the end: -> next step.
- Next step:
  - If idx==0 -> SNAP (new frame, no IDLE cycle in between).
  - Else idx<=idx-1 -> SHOW.
- Frame length = 1 + N*(DWELL_CYCLES+BLANK_CYCLES), where N = number of nibbles shown (8, or start index+1 when suppressing).
- Latency:
  - value is sampled on the SNAP edge.
  - The first nibble is visible on the cycle after SNAP.
  - Changes to value outside SNAP have no effect.
- Dwell counter:
  - Width $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1).
  - Reloaded on every state entry; counts down to 1; no wrap.
- Enable deasserted in SHOW/GAP/SNAP:
  - -> IDLE on the next edge, blank=1.
  - The snapshot is retained.
  - Re-enable always starts a fresh frame via SNAP from the start index.
- enable=1 and hold=1 simultaneously at SNAP: the old snapshot is redisplayed, and the start index is recomputed from it.
- Reset asserted mid-operation: immediate return to reset values; no partial frame resumes.

Test Plan:
(Bench parameters: DWELL_CYCLES=4, BLANK_CYCLES=2.)
1. Reset and idle.
   - Stimulus: hold reset=0, then release it with enable=0.
   - Required: blank=1, nibble_value=0, nibble_idx=0, frame_start=0 throughout.
2. Full frame, SUPPRESS_LZ=0.
   - Stimulus: value=0x1234ABCD, enable=1.
   - Required: one frame_start pulse, then idx 7..0 show 1,2,3,4,A,B,C,D for 4 cycles each with blank=0. Each is followed by 2 cycles of blank=1. The next frame_start comes 49 cycles after the previous one.
3. Leading-zero suppression, SUPPRESS_LZ=1.
   - Stimulus: value=0x000000A5.
   - Required: only idx1='A' then idx0='5' are shown, with a 13-cycle frame period.
   - Stimulus: value=0.
   - Required: a single idx0='0' with a 7-cycle period.
4. Snapshot and hold.
   - Stimulus: change value to 0xFFFFFFFF mid-frame.
   - Required: the current frame is unchanged; the new value appears from the next SNAP.
   - Stimulus: hold=1 at SNAP.
   - Required: the previous snapshot digits repeat.
5. Enable drop.
   - Stimulus: deassert enable during SHOW of idx 4.
   - Required: blank=1 and IDLE on the next edge.
   - Stimulus: reassert enable.
   - Required: SNAP (frame_start=1), then display restarts at idx 7.
6. Async reset mid-operation.
   - Stimulus: drive reset=0 between clock edges during GAP.
   - Required: outputs reach reset values before the next edge; after release with enable=1, the first frame_start occurs one cycle later.

Source files
------------

// File: rtl/display_nibble_scheduler.sv
// Steps a snapshotted word onto one seven-segment decoder, MSN first, with a
// dwell per nibble and an optional blank gap between digits.
module display_nibble_scheduler #(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 100,
  parameter int NUM_NIBBLES  = 8,
  parameter bit SUPPRESS_LZ  = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [4*NUM_NIBBLES-1:0]   value,
  input  logic                       hold,
  output logic [3:0]                 nibble_value,
  output logic [$clog2(NUM_NIBBLES)-1:0] nibble_idx,
  output logic                       blank,
  output logic                       frame_start
);

  localparam int IW   = $clog2(NUM_NIBBLES);
  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, SNAP, SHOW, GAP} state_e;

  state_e                        state_q, state_d;
  logic [NUM_NIBBLES-1:0][3:0]   snap_q, snap_d, snap_next;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [IW-1:0]                 idx_q, idx_d, start_idx;
  logic [3:0]                    nval_q, nval_d;
  logic                          blank_q, blank_d;
  logic                          fs_q, fs_d;
  logic [NUM_NIBBLES-1:0]        nz;
  logic                          advance;

  // Word that SHOW will use if this cycle is SNAP; hold keeps the old one.
  assign snap_next = hold ? snap_q : value;

  for (genvar g = 0; g < NUM_NIBBLES; g++) begin : g_nz
    assign nz[g] = |snap_next[g];
  end

  function automatic logic [IW-1:0] msn(input logic [NUM_NIBBLES-1:0] v);
    msn = '0;
    for (int i = 0; i < NUM_NIBBLES; i++)
      if (v[i]) msn = IW'(i);
  endfunction

  assign start_idx = SUPPRESS_LZ ? msn(nz) : IW'(NUM_NIBBLES - 1);

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    nval_d  = nval_q;
    blank_d = 1'b1;
    fs_d    = 1'b0;
    advance = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SNAP;
          cnt_d   = CW'(1);
          fs_d    = 1'b1;
        end
        SNAP: begin
          snap_d  = snap_next;
          state_d = SHOW;
          cnt_d   = CW'(DWELL_CYCLES);
          idx_d   = start_idx;
          nval_d  = snap_next[start_idx];
          blank_d = 1'b0;
        end
        SHOW: begin
          if (cnt_q == CW'(1)) begin
            if (BLANK_CYCLES > 0) begin
              state_d = GAP;
              cnt_d   = CW'(BLANK_CYCLES);
            end else begin
              advance = 1'b1;
            end
          end else begin
            cnt_d   = cnt_q - CW'(1);
            blank_d = 1'b0;
          end
        end
        GAP: begin
          if (cnt_q == CW'(1)) advance = 1'b1;
          else                 cnt_d   = cnt_q - CW'(1);
        end
        default: state_d = IDLE;
      endcase
      // End of a digit: either wrap to a fresh frame or step down one nibble.
      if (advance) begin
        if (idx_q == '0) begin
          state_d = SNAP;
          cnt_d   = CW'(1);
          fs_d    = 1'b1;
        end else begin
          state_d = SHOW;
          cnt_d   = CW'(DWELL_CYCLES);
          idx_d   = idx_q - IW'(1);
          nval_d  = snap_q[idx_q - IW'(1)];
          blank_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      snap_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      nval_q  <= '0;
      blank_q <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      nval_q  <= nval_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
    end
  end

  assign nibble_value = nval_q;
  assign nibble_idx   = idx_q;
  assign blank        = blank_q;
  assign frame_start  = fs_q;

endmodule

// File: tb/tb_display_nibble_scheduler.sv
// Directed bench: one instance without and one with leading-zero suppression,
// DWELL=4, BLANK=2, shared stimulus.
module tb_display_nibble_scheduler;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] value;
  logic        hold;
  logic [3:0]  nv0, nv1;
  logic [2:0]  ix0, ix1;
  logic        bl0, bl1, fs0, fs1;
  int          n_cmp = 0;
  int          n_err = 0;

  display_nibble_scheduler #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .NUM_NIBBLES(8), .SUPPRESS_LZ(1'b0)) u_full (
    .clk(clk), .reset(reset), .enable(enable), .value(value), .hold(hold),
    .nibble_value(nv0), .nibble_idx(ix0), .blank(bl0), .frame_start(fs0));

  display_nibble_scheduler #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .NUM_NIBBLES(8), .SUPPRESS_LZ(1'b1)) u_lz (
    .clk(clk), .reset(reset), .enable(enable), .value(value), .hold(hold),
    .nibble_value(nv1), .nibble_idx(ix1), .blank(bl1), .frame_start(fs1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {frame_start, blank, idx, value}
  function automatic logic [8:0] outs(input bit sel);
    return sel ? {fs1, bl1, ix1, nv1} : {fs0, bl0, ix0, nv0};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_idle(input bit sel, input string tag);
    logic [8:0] o;
    o = outs(sel);
    chk({tag, "_fs"},    32'(o[8]),   32'd0);
    chk({tag, "_blank"}, 32'(o[7]),   32'd1);
    chk({tag, "_idx"},   32'(o[6:4]), 32'd0);
    chk({tag, "_val"},   32'(o[3:0]), 32'd0);
  endtask

  task automatic check_snap(input bit sel, input string tag);
    logic [8:0] o;
    o = outs(sel);
    chk({tag, "_fs"},    32'(o[8]), 32'd1);
    chk({tag, "_blank"}, 32'(o[7]), 32'd1);
  endtask

  task automatic check_show(input bit sel, input int idx, input logic [3:0] dig, input bit gap);
    logic [8:0] o;
    o = outs(sel);
    chk($sformatf("d%0d_i%0d_fs", sel, idx),    32'(o[8]),   32'd0);
    chk($sformatf("d%0d_i%0d_blank", sel, idx), 32'(o[7]),   32'(gap));
    chk($sformatf("d%0d_i%0d_idx", sel, idx),   32'(o[6:4]), 32'(idx));
    chk($sformatf("d%0d_i%0d_val", sel, idx),   32'(o[3:0]), 32'(dig));
  endtask

  // One digit: 4 dwell cycles then 2 blank cycles holding idx/value.
  task automatic show_digit(input bit sel, input int idx, input logic [3:0] dig);
    for (int c = 0; c < 4; c++) begin tick(); check_show(sel, idx, dig, 1'b0); end
    for (int c = 0; c < 2; c++) begin tick(); check_show(sel, idx, dig, 1'b1); end
  endtask

  initial begin
    logic [31:0] w;
    reset = 1'b0; enable = 1'b0; value = 32'h0; hold = 1'b0;

    // 1. reset and idle
    tick(); check_idle(0, "rst0"); check_idle(1, "rst1");
    tick(); reset = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); check_idle(0, "idle0"); check_idle(1, "idle1"); end

    // 2. full frame, then 4. mid-frame change and hold
    value = 32'h1234_ABCD; enable = 1'b1;
    tick(); check_snap(0, "snap_a");
    w = 32'h1234_ABCD;
    for (int i = 7; i >= 0; i--) show_digit(0, i, w[4*i +: 4]);
    tick(); check_snap(0, "snap_a2");
    for (int i = 7; i >= 0; i--) begin
      show_digit(0, i, w[4*i +: 4]);
      if (i == 7) value = 32'hFFFF_FFFF;
    end
    tick(); check_snap(0, "snap_f");
    for (int i = 7; i >= 0; i--) begin
      show_digit(0, i, 4'hF);
      if (i == 7) begin hold = 1'b1; value = 32'h0; end
    end
    tick(); check_snap(0, "snap_hold");
    for (int i = 7; i >= 0; i--) begin
      show_digit(0, i, 4'hF);
      if (i == 7) hold = 1'b0;
    end

    // 3. leading-zero suppression
    reset = 1'b0; enable = 1'b0; value = 32'h0000_00A5;
    tick(); reset = 1'b1;
    tick(); enable = 1'b1;
    tick(); check_snap(1, "lz_snap1");
    show_digit(1, 1, 4'hA); show_digit(1, 0, 4'h5);
    tick(); check_snap(1, "lz_snap2");
    show_digit(1, 1, 4'hA); value = 32'h0;
    show_digit(1, 0, 4'h5);
    tick(); check_snap(1, "lz_snap3");
    show_digit(1, 0, 4'h0);
    tick(); check_snap(1, "lz_snap4");
    show_digit(1, 0, 4'h0);
    tick(); check_snap(1, "lz_snap5");

    // 5. enable drop during idx 4
    reset = 1'b0; enable = 1'b0; value = 32'h1234_ABCD;
    tick(); reset = 1'b1;
    tick(); enable = 1'b1;
    tick(); check_snap(0, "en_snap");
    show_digit(0, 7, 4'h1); show_digit(0, 6, 4'h2); show_digit(0, 5, 4'h3);
    tick(); check_show(0, 4, 4'h4, 1'b0);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drop_blank", 32'(bl0), 32'd1);
      chk("drop_fs",    32'(fs0), 32'd0);
    end
    enable = 1'b1;
    tick(); check_snap(0, "reen_snap");
    for (int c = 0; c < 4; c++) begin tick(); check_show(0, 7, 4'h1, 1'b0); end

    // 6. async reset in the gap
    tick(); check_show(0, 7, 4'h1, 1'b1);
    #2 reset = 1'b0;
    #1 check_idle(0, "async_rst");
    tick(); check_idle(0, "async_hold");
    reset = 1'b1;
    tick(); check_snap(0, "post_rst_snap");
    tick(); check_show(0, 7, 4'h1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
